// File: rtl/excp_unit_pkg.sv
// Shared CPU definitions for exception/interrupt handling: CSR snapshot, CSR
// write request, exception codes and ESTAT.IS bit positions.
package excp_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IS_W    = 13;
    localparam int unsigned LIE_W   = 13;
    localparam int unsigned ECODE_W = 6;
    localparam int unsigned ESUB_W  = 9;
    localparam int unsigned VPPN_W  = 19;
    localparam int unsigned HWI_W   = 8;
    localparam int unsigned SWI_W   = 2;
    localparam int unsigned PLV_W   = 2;

    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_PIL  = 6'h01;
    localparam logic [ECODE_W-1:0] ECODE_PIS  = 6'h02;
    localparam logic [ECODE_W-1:0] ECODE_PIF  = 6'h03;
    localparam logic [ECODE_W-1:0] ECODE_PME  = 6'h04;
    localparam logic [ECODE_W-1:0] ECODE_PPI  = 6'h07;
    localparam logic [ECODE_W-1:0] ECODE_TLBR = 6'h3f;

    localparam int unsigned IS_SWI_LSB = 0;
    localparam int unsigned IS_HWI_LSB = 2;
    localparam int unsigned IS_RSVD    = 10;
    localparam int unsigned IS_TI      = 11;
    localparam int unsigned IS_IPI     = 12;

    typedef struct packed {
        logic [PLV_W-1:0] plv;
        logic             ie;
        logic             da;
        logic             pg;
    } crmd_t;

    typedef struct packed {
        logic [PLV_W-1:0] pplv;
        logic             pie;
    } prmd_t;

    typedef struct packed {
        logic [LIE_W-1:0] lie;
    } ecfg_t;

    typedef struct packed {
        logic [ECODE_W-1:0] ecode;
        logic [ESUB_W-1:0]  esubcode;
    } estat_t;

    typedef struct packed {
        logic [VPPN_W-1:0] vppn;
    } tlbehi_t;

    typedef struct packed {
        crmd_t           crmd;
        ecfg_t           ecfg;
        logic [XLEN-1:0] era;
        logic [XLEN-1:0] badv;
        logic [XLEN-1:0] eentry;
        logic [XLEN-1:0] tlbrentry;
        tlbehi_t         tlbehi;
    } csr_t;

    typedef struct packed {
        logic            we;
        crmd_t           crmd;
        prmd_t           prmd;
        estat_t          estat;
        logic [XLEN-1:0] era;
        logic [XLEN-1:0] badv;
        tlbehi_t         tlbehi;
    } excp_wr_csr_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_DRAIN = 2'd2
    } excp_state_e;

    // Exceptions whose faulting address must also land in TLBEHI.VPPN.
    function automatic logic ecode_loads_vppn(input logic [ECODE_W-1:0] ecode);
        return (ecode == ECODE_TLBR) || (ecode == ECODE_PIL) || (ecode == ECODE_PIS) ||
               (ecode == ECODE_PIF)  || (ecode == ECODE_PME) || (ecode == ECODE_PPI);
    endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop level synchronizer for asynchronous interrupt lines.
module int_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/excp_unit.sv
// Commit-point exception/interrupt unit: tracks pending interrupts, arbitrates
// trap events and issues the CSR write, redirect and flush for one trap.
module excp_unit
    import excp_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmt_valid,
    input  logic [XLEN-1:0]      cmt_pc,
    input  logic                 cmt_excp,
    input  logic [ECODE_W-1:0]   cmt_ecode,
    input  logic [ESUB_W-1:0]    cmt_esubcode,
    input  logic                 cmt_badv_we,
    input  logic [XLEN-1:0]      cmt_badv,
    input  logic                 cmt_ertn,
    input  csr_t                 excp_rd,
    input  logic [SWI_W-1:0]     swi,
    input  logic [SWI_W-1:0]     swi_clr,
    input  logic                 ti,
    input  logic                 ti_clr,
    input  logic [HWI_W-1:0]     hwi,
    input  logic                 ipi,
    output logic [IS_W-1:0]      is,
    output excp_wr_csr_req_t     excp_wr_req,
    output logic                 cmt_ready,
    output logic                 redirect,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 flush
);

    localparam int unsigned SYNC_W = HWI_W + 1;

    logic [SYNC_W-1:0] sync_lvl;
    logic [SWI_W-1:0]  swi_q, swi_d;
    logic              ti_q, ti_d;

    excp_state_e       state_q, state_d;
    logic              cmt_ready_q, cmt_ready_d;
    logic              redirect_q, redirect_d;
    logic              flush_q, flush_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    excp_wr_csr_req_t  wr_q, wr_d;

    logic              int_take_c;
    logic              trap_evt_c;
    logic [ECODE_W-1:0] ecode_c;
    logic [ESUB_W-1:0]  esub_c;
    logic              is_tlbr_c;

    // ipi shares the hwi synchronizer so both see the same 2-cycle latency.
    int_sync #(
        .WIDTH (SYNC_W)
    ) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i ({ipi, hwi}),
        .sync_o  (sync_lvl)
    );

    // Sticky software/timer sources; a set in the same cycle as a clear wins.
    always_comb begin
        swi_d = (swi_q & ~swi_clr) | swi;
        ti_d  = (ti_q & ~ti_clr) | ti;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            swi_q <= '0;
            ti_q  <= 1'b0;
        end else begin
            swi_q <= swi_d;
            ti_q  <= ti_d;
        end
    end

    assign is = {sync_lvl[HWI_W], ti_q, 1'b0, sync_lvl[HWI_W-1:0], swi_q};

    assign int_take_c = excp_rd.crmd.ie && (|(is & excp_rd.ecfg.lie));
    assign trap_evt_c = cmt_valid && (int_take_c || cmt_excp || cmt_ertn);

    // Next state and next registered outputs; trap payload is built from the
    // CSR snapshot present in the acceptance cycle.
    always_comb begin
        state_d       = state_q;
        cmt_ready_d   = 1'b0;
        redirect_d    = 1'b0;
        flush_d       = 1'b0;
        redirect_pc_d = '0;
        wr_d          = '0;
        ecode_c       = int_take_c ? ECODE_INT : cmt_ecode;
        esub_c        = int_take_c ? ESUB_W'(0) : cmt_esubcode;
        is_tlbr_c     = !int_take_c && (cmt_ecode == ECODE_TLBR);

        case (state_q)
            ST_IDLE: begin
                cmt_ready_d = 1'b1;
                if (trap_evt_c) begin
                    state_d     = ST_TRAP;
                    cmt_ready_d = 1'b0;
                    redirect_d  = 1'b1;
                    flush_d     = 1'b1;
                    if (int_take_c || cmt_excp) begin
                        wr_d.we             = 1'b1;
                        wr_d.prmd.pplv      = excp_rd.crmd.plv;
                        wr_d.prmd.pie       = excp_rd.crmd.ie;
                        wr_d.crmd           = excp_rd.crmd;
                        wr_d.crmd.plv       = '0;
                        wr_d.crmd.ie        = 1'b0;
                        wr_d.era            = cmt_pc;
                        wr_d.estat.ecode    = ecode_c;
                        wr_d.estat.esubcode = esub_c;
                        wr_d.badv           = (!int_take_c && cmt_badv_we) ? cmt_badv
                                                                          : excp_rd.badv;
                        wr_d.tlbehi         = excp_rd.tlbehi;
                        if (!int_take_c && ecode_loads_vppn(cmt_ecode)) begin
                            wr_d.tlbehi.vppn = cmt_badv[XLEN-1:XLEN-VPPN_W];
                        end
                        if (is_tlbr_c) begin
                            wr_d.crmd.da  = 1'b1;
                            wr_d.crmd.pg  = 1'b0;
                            redirect_pc_d = excp_rd.tlbrentry;
                        end else begin
                            redirect_pc_d = excp_rd.eentry;
                        end
                    end else begin
                        redirect_pc_d = excp_rd.era;
                    end
                end
            end
            ST_TRAP: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d     = ST_IDLE;
                cmt_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                cmt_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cmt_ready_q   <= 1'b1;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            wr_q          <= '0;
        end else begin
            state_q       <= state_d;
            cmt_ready_q   <= cmt_ready_d;
            redirect_q    <= redirect_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            wr_q          <= wr_d;
        end
    end

    assign cmt_ready   = cmt_ready_q;
    assign redirect    = redirect_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign excp_wr_req = wr_q;

endmodule

// File: tb/tb_excp_unit.sv
// Directed bench for excp_unit: interrupt/exception/ERTN traps, pending-source
// set/clear rules, synchronizer latency and reset abort.
module tb_excp_unit;
    import excp_unit_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 cmt_valid;
    logic [XLEN-1:0]      cmt_pc;
    logic                 cmt_excp;
    logic [ECODE_W-1:0]   cmt_ecode;
    logic [ESUB_W-1:0]    cmt_esubcode;
    logic                 cmt_badv_we;
    logic [XLEN-1:0]      cmt_badv;
    logic                 cmt_ertn;
    csr_t                 csr;
    logic [SWI_W-1:0]     swi;
    logic [SWI_W-1:0]     swi_clr;
    logic                 ti;
    logic                 ti_clr;
    logic [HWI_W-1:0]     hwi;
    logic                 ipi;
    logic [IS_W-1:0]      is;
    excp_wr_csr_req_t     wr;
    logic                 cmt_ready;
    logic                 redirect;
    logic [XLEN-1:0]      redirect_pc;
    logic                 flush;

    int total = 0;
    int bad   = 0;

    excp_unit dut (
        .clk          (clk),
        .rst          (rst),
        .cmt_valid    (cmt_valid),
        .cmt_pc       (cmt_pc),
        .cmt_excp     (cmt_excp),
        .cmt_ecode    (cmt_ecode),
        .cmt_esubcode (cmt_esubcode),
        .cmt_badv_we  (cmt_badv_we),
        .cmt_badv     (cmt_badv),
        .cmt_ertn     (cmt_ertn),
        .excp_rd      (csr),
        .swi          (swi),
        .swi_clr      (swi_clr),
        .ti           (ti),
        .ti_clr       (ti_clr),
        .hwi          (hwi),
        .ipi          (ipi),
        .is           (is),
        .excp_wr_req  (wr),
        .cmt_ready    (cmt_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_commit();
        cmt_valid    = 1'b0;
        cmt_excp     = 1'b0;
        cmt_ertn     = 1'b0;
        cmt_badv_we  = 1'b0;
        cmt_ecode    = '0;
        cmt_esubcode = '0;
        cmt_badv     = '0;
        cmt_pc       = '0;
    endtask

    initial begin
        rst     = 1'b1;
        swi     = '0;
        swi_clr = '0;
        ti      = 1'b0;
        ti_clr  = 1'b0;
        hwi     = '0;
        ipi     = 1'b0;
        clear_commit();
        csr.crmd.plv    = 2'd3;
        csr.crmd.ie     = 1'b1;
        csr.crmd.da     = 1'b0;
        csr.crmd.pg     = 1'b1;
        csr.ecfg.lie    = 13'h800;
        csr.era         = 32'h1c00_0200;
        csr.badv        = 32'hdead_beef;
        csr.eentry      = 32'h1c00_8000;
        csr.tlbrentry   = 32'h1c00_f000;
        csr.tlbehi.vppn = 19'h12345;

        tick();
        tick();
        check("rst_is",        32'(is), 32'h0);
        check("rst_ready",     32'(cmt_ready), 32'h1);
        check("rst_redirect",  32'(redirect), 32'h0);
        check("rst_flush",     32'(flush), 32'h0);
        check("rst_we",        32'(wr.we), 32'h0);
        check("rst_rpc",       redirect_pc, 32'h0);
        rst = 1'b0;
        tick();

        // timer interrupt taken at commit
        ti = 1'b1;
        tick();
        ti = 1'b0;
        check("ti_pending", 32'(is), 32'h800);
        cmt_valid = 1'b1;
        cmt_pc    = 32'h1c00_0100;
        tick();
        clear_commit();
        check("int_redirect", 32'(redirect), 32'h1);
        check("int_flush",    32'(flush), 32'h1);
        check("int_we",       32'(wr.we), 32'h1);
        check("int_ecode",    32'(wr.estat.ecode), 32'h0);
        check("int_esub",     32'(wr.estat.esubcode), 32'h0);
        check("int_era",      wr.era, 32'h1c00_0100);
        check("int_rpc",      redirect_pc, 32'h1c00_8000);
        check("int_pplv",     32'(wr.prmd.pplv), 32'h3);
        check("int_pie",      32'(wr.prmd.pie), 32'h1);
        check("int_crmd",     32'(wr.crmd), 32'h01);
        check("int_badv",     wr.badv, 32'hdead_beef);
        check("int_ready",    32'(cmt_ready), 32'h0);
        ti_clr = 1'b1;
        tick();
        ti_clr = 1'b0;
        check("drain_redirect", 32'(redirect), 32'h0);
        check("drain_we",       32'(wr.we), 32'h0);
        check("drain_flush",    32'(flush), 32'h0);
        check("drain_ready",    32'(cmt_ready), 32'h0);
        check("ti_cleared",     32'(is), 32'h0);
        tick();
        check("idle_ready", 32'(cmt_ready), 32'h1);

        // TLB refill exception
        cmt_valid   = 1'b1;
        cmt_pc      = 32'h1c00_0300;
        cmt_excp    = 1'b1;
        cmt_ecode   = ECODE_TLBR;
        cmt_badv_we = 1'b1;
        cmt_badv    = 32'h0040_3000;
        tick();
        clear_commit();
        check("tlbr_we",    32'(wr.we), 32'h1);
        check("tlbr_crmd",  32'(wr.crmd), 32'h02);
        check("tlbr_vppn",  32'(wr.tlbehi.vppn), 32'h00201);
        check("tlbr_badv",  wr.badv, 32'h0040_3000);
        check("tlbr_ecode", 32'(wr.estat.ecode), 32'h3f);
        check("tlbr_rpc",   redirect_pc, 32'h1c00_f000);
        tick();
        tick();

        // plain exception, no badv update, keeps vppn
        cmt_valid    = 1'b1;
        cmt_pc       = 32'h1c00_0400;
        cmt_excp     = 1'b1;
        cmt_ecode    = 6'h0b;
        cmt_esubcode = 9'h005;
        cmt_badv     = 32'h1234_6000;
        tick();
        clear_commit();
        check("sys_esub", 32'(wr.estat.esubcode), 32'h005);
        check("sys_badv", wr.badv, 32'hdead_beef);
        check("sys_vppn", 32'(wr.tlbehi.vppn), 32'h12345);
        check("sys_crmd", 32'(wr.crmd), 32'h01);
        check("sys_rpc",  redirect_pc, 32'h1c00_8000);
        tick();
        tick();

        // PIL loads vppn but stays on eentry
        cmt_valid   = 1'b1;
        cmt_excp    = 1'b1;
        cmt_ecode   = ECODE_PIL;
        cmt_badv_we = 1'b1;
        cmt_badv    = 32'h1234_6000;
        tick();
        clear_commit();
        check("pil_vppn", 32'(wr.tlbehi.vppn), 32'h091a3);
        check("pil_badv", wr.badv, 32'h1234_6000);
        check("pil_rpc",  redirect_pc, 32'h1c00_8000);
        tick();
        tick();

        // ti set and clear together: set wins
        ti     = 1'b1;
        ti_clr = 1'b1;
        tick();
        ti = 1'b0;
        check("ti_setwins", 32'(is[IS_TI]), 32'h1);
        tick();
        ti_clr = 1'b0;
        check("ti_clr_alone", 32'(is[IS_TI]), 32'h0);

        // hwi synchronizer latency, then masked by crmd.ie=0
        hwi = 8'h08;
        tick();
        check("hwi_lat1", 32'(is), 32'h000);
        tick();
        check("hwi_lat2", 32'(is), 32'h020);
        csr.crmd.ie = 1'b0;
        csr.ecfg.lie = 13'h020;
        cmt_valid = 1'b1;
        tick();
        clear_commit();
        check("ie0_ready",    32'(cmt_ready), 32'h1);
        check("ie0_redirect", 32'(redirect), 32'h0);
        check("ie0_we",       32'(wr.we), 32'h0);

        // interrupt outranks exception and ERTN on the same commit
        csr.crmd.ie  = 1'b1;
        cmt_valid    = 1'b1;
        cmt_pc       = 32'h1c00_0500;
        cmt_excp     = 1'b1;
        cmt_ertn     = 1'b1;
        cmt_ecode    = ECODE_TLBR;
        cmt_badv_we  = 1'b1;
        cmt_badv     = 32'h0040_3000;
        tick();
        clear_commit();
        hwi = 8'h00;
        check("prio_ecode", 32'(wr.estat.ecode), 32'h0);
        check("prio_badv",  wr.badv, 32'hdead_beef);
        check("prio_vppn",  32'(wr.tlbehi.vppn), 32'h12345);
        check("prio_era",   wr.era, 32'h1c00_0500);
        check("prio_rpc",   redirect_pc, 32'h1c00_8000);
        tick();
        tick();
        check("hwi_dropped", 32'(is), 32'h0);
        csr.ecfg.lie = 13'h800;

        // ERTN
        cmt_valid = 1'b1;
        cmt_ertn  = 1'b1;
        tick();
        clear_commit();
        check("ertn_redirect", 32'(redirect), 32'h1);
        check("ertn_rpc",      redirect_pc, 32'h1c00_0200);
        check("ertn_we",       32'(wr.we), 32'h0);
        tick();
        check("ertn_drain_ready", 32'(cmt_ready), 32'h0);
        tick();

        // swi set/clear together: set wins
        swi     = 2'b10;
        swi_clr = 2'b10;
        tick();
        swi = 2'b00;
        check("swi_setwins", 32'(is), 32'h002);
        tick();
        swi_clr = 2'b00;
        check("swi_clr", 32'(is), 32'h000);

        // reset during TRAP aborts the event
        swi = 2'b01;
        tick();
        swi = 2'b00;
        check("swi_pending", 32'(is), 32'h001);
        cmt_valid = 1'b1;
        cmt_excp  = 1'b1;
        cmt_ecode = 6'h0b;
        tick();
        clear_commit();
        check("abort_trap_we", 32'(wr.we), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready",    32'(cmt_ready), 32'h1);
        check("abort_is",       32'(is), 32'h0);
        check("abort_we",       32'(wr.we), 32'h0);
        check("abort_redirect", 32'(redirect), 32'h0);
        check("abort_rpc",      redirect_pc, 32'h0);
        tick();
        check("post_we",    32'(wr.we), 32'h0);
        check("post_flush", 32'(flush), 32'h0);
        check("post_ready", 32'(cmt_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
